data_mem_responder: RTL and testbench

Data-memory responder for the RISC-V datapath. It accepts load/store requests (address from the ALU result, store data from the register file's second read port) over a valid/ready handshake. Each accepted request is served after a programmable number of wait states from an internal word array with per-byte write strobes. A one-cycle response pulse returns read data or an error flag, and the core stalls on it.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/byte_lane_ram.sv | 35 +++
 rtl/data_mem_responder.sv | 128 ++++++++++++
 tb/tb_data_mem_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, word
// geometry and wait-counter width.
package dmem_pkg;

  // Responder FSM states; encodings are fixed so debug probes stay stable.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  // Bytes per memory word.
  localparam int WORD_BYTES = 4;

  // Wait-state counter width; supports 0..15 wait cycles.
  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/byte_lane_ram.sv
// Single-port word RAM with per-byte write strobes and a registered read.
// Read-first: a combined read/write returns the word as it was before the write.
module byte_lane_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  output logic [31:0]      rdata
);

  // Storage is deliberately not reset so it maps onto block RAM.
  logic [31:0] mem [DEPTH_WORDS];

  // One access per enable: strobed byte writes plus a registered word read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
          if (wstrb[b]) begin
            mem[idx][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store over valid/ready, waits a
// fixed number of cycles, performs the access and returns a one-cycle
// response carrying read data or an error flag.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  // Size of the mapped window in bytes, one bit wider so the top is representable.
  localparam logic [32:0] SPAN  = 33'(WORD_BYTES * DEPTH_WORDS);

  state_t state;
  cnt_t   cnt;

  // Request captured at the accept edge; later input changes are ignored.
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;

  // Response registers, updated only at the execute edge.
  logic resp_valid_reg;
  logic err_reg;
  logic rd_sel_reg;   // 1 when the last response was a successful load

  logic [31:0]      offset;
  logic             misaligned;
  logic             below_base;
  logic             out_of_range;
  logic             strobe_err;
  logic             access_err;
  logic             execute;
  logic             ram_en;
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      ram_rdata;

  // Address decode works on the full 32-bit offset, so anything outside the
  // window is flagged before the index is truncated to RAM width.
  assign offset       = addr_reg - BASE_ADDR;
  assign misaligned   = (addr_reg[1:0] != 2'b00);
  assign below_base   = (addr_reg < BASE_ADDR);
  assign out_of_range = ({1'b0, offset} >= SPAN);
  assign strobe_err   = we_reg && (wstrb_reg == 4'b0000);
  assign access_err   = misaligned || below_base || out_of_range || strobe_err;
  assign ram_idx      = offset[IDX_W+1:2];

  // The access happens on the last BUSY edge; reset at that edge blocks it.
  assign execute = (state == BUSY) && (cnt == '0);
  assign ram_en  = execute && !access_err && !reset;

  byte_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (we_reg),
    .idx  (ram_idx),
    .wdata(wdata_reg),
    .wstrb(wstrb_reg),
    .rdata(ram_rdata)
  );

  assign req_ready  = (state == IDLE) && !reset;
  assign resp_valid = resp_valid_reg;
  assign resp_err   = err_reg;
  // RAM output only changes on an access, so the masked word holds until the next one.
  assign resp_rdata = rd_sel_reg ? ram_rdata : 32'h0000_0000;

  // Request sequencing: capture, count wait states, execute, pulse the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      resp_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
      rd_sel_reg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid_reg <= 1'b0;
          if (req_valid) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            wstrb_reg <= req_wstrb;
            cnt       <= cnt_t'(WAIT_CYCLES);
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            err_reg        <= access_err;
            rd_sel_reg     <= !we_reg && !access_err;
            resp_valid_reg <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          resp_valid_reg <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          resp_valid_reg <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: instance 0 uses WAIT_CYCLES=2,
// instance 1 uses WAIT_CYCLES=0. Expected responses come from a word-array
// model updated when each request is issued.
module tb_data_mem_responder;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid_s [2];
  logic        req_we_s    [2];
  logic [31:0] req_addr_s  [2];
  logic [31:0] req_wdata_s [2];
  logic [3:0]  req_wstrb_s [2];
  logic        req_ready_s [2];
  logic        resp_valid_s[2];
  logic [31:0] resp_rdata_s[2];
  logic        resp_err_s  [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      data_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(gi == 0 ? 2 : 0),
        .BASE_ADDR  (BASE)
      ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid_s[gi]),
        .req_ready (req_ready_s[gi]),
        .req_we    (req_we_s[gi]),
        .req_addr  (req_addr_s[gi]),
        .req_wdata (req_wdata_s[gi]),
        .req_wstrb (req_wstrb_s[gi]),
        .resp_valid(resp_valid_s[gi]),
        .resp_rdata(resp_rdata_s[gi]),
        .resp_err  (resp_err_s[gi])
      );
    end
  endgenerate

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mdl [2][DEPTH];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(int s);
    return (s == 0) ? 2 : 0;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Reference: a word array addressed by byte offset / 4, with the error rules
  // applied arithmetically on the full address.
  function automatic exp_t predict(int s, logic we, logic [31:0] addr,
                                   logic [31:0] wdata, logic [3:0] strb, int acc);
    exp_t   e;
    longint off;
    int     i;
    off     = longint'(addr) - longint'(BASE);
    e.err   = (addr % 4 != 0) || (off < 0) || (off >= 4 * DEPTH) || (we && strb == 4'd0);
    e.rdata = 32'h0;
    e.due   = acc + wait_of(s) + 2;
    if (!e.err) begin
      i = int'(off / 4);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) mdl[s][i][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        e.rdata = mdl[s][i];
      end
    end
    return e;
  endfunction

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      if (resp_valid_s[s] === 1'b1) begin
        if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp dut%0d: resp_valid=1 at cycle %0d, expected 0", s, cyc);
        end else begin
          e = (s == 0) ? q0.pop_front() : q1.pop_front();
          $display("resp dut%0d cycle=%0d rdata=%h err=%0d", s, cyc, resp_rdata_s[s], resp_err_s[s]);
          chk($sformatf("rdata dut%0d", s), resp_rdata_s[s], e.rdata);
          chk($sformatf("err dut%0d", s), 32'(resp_err_s[s]), 32'(e.err));
          chk($sformatf("latency dut%0d", s), cyc, e.due);
        end
      end
    end
  end

  // Drives one request (called at a falling edge); returns the accept cycle.
  task automatic issue(input int s, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input bit track, output int acc);
    int n;
    exp_t e;
    req_valid_s[s] = 1'b1;
    req_we_s[s]    = we;
    req_addr_s[s]  = addr;
    req_wdata_s[s] = wdata;
    req_wstrb_s[s] = strb;
    n = 0;
    while (req_ready_s[s] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: req_ready=%b, expected 1 within 50 cycles", s, req_ready_s[s]);
      req_valid_s[s] = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (track) begin
      e = predict(s, we, addr, wdata, strb, acc);
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(negedge clk);
    // Garbage on the request bus while busy must not matter.
    req_valid_s[s] = 1'b0;
    req_we_s[s]    = 1'($urandom);
    req_addr_s[s]  = $urandom;
    req_wdata_s[s] = $urandom;
    req_wstrb_s[s] = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: %0d/%0d responses outstanding, expected 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int a, a1, a2, prev, na, pulses, r;
    logic [31:0] addr;
    for (int s = 0; s < 2; s++) begin
      req_valid_s[s] = 1'b0; req_we_s[s] = 1'b0; req_addr_s[s] = '0;
      req_wdata_s[s] = '0;   req_wstrb_s[s] = '0;
      for (int i = 0; i < DEPTH; i++) mdl[s][i] = 32'h0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("ready_during_reset", 32'(req_ready_s[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready_s[0]), 32'd1);
    chk("resp_valid_after_reset", 32'(resp_valid_s[0]), 32'd0);
    chk("rdata_after_reset", resp_rdata_s[0], 32'd0);
    chk("err_after_reset", 32'(resp_err_s[0]), 32'd0);

    // Store then load, full word.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, a);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, a);
    // Partial store merges one byte.
    issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1, a);
    issue(0, 1'b1, 32'h20, 32'hFFFFBBFF, 4'b0010, 1'b1, a);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, a);
    // Out-of-range and misaligned accesses.
    issue(0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b1, a);
    issue(0, 1'b1, 32'h400, 32'hAAAAAAAA, 4'hF, 1'b1, a);
    issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a);
    issue(0, 1'b1, 32'h12, 32'h01020304, 4'hF, 1'b1, a);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, a);
    issue(0, 1'b1, 32'h14, 32'h01020304, 4'h0, 1'b1, a);
    wait_idle();

    // req_valid held high with the address moving every cycle.
    prev = -1;
    na   = 0;
    for (int k = 0; k < 20; k++) begin
      req_valid_s[0] = 1'b1;
      req_we_s[0]    = 1'b0;
      req_addr_s[0]  = 32'h40 + 32'(4 * k);
      if (req_ready_s[0] === 1'b1) begin
        q0.push_back(predict(0, 1'b0, req_addr_s[0], 32'h0, 4'h0, cyc));
        if (prev >= 0) chk("accept_spacing", 32'(cyc - prev), 32'd5);
        prev = cyc;
        na++;
      end
      @(negedge clk);
    end
    req_valid_s[0] = 1'b0;
    chk("accepts_in_20_cycles", 32'(na), 32'd4);
    wait_idle();

    // Reset in cycle 2 of a store discards it.
    issue(0, 1'b1, 32'h30, 32'h55, 4'hF, 1'b0, a);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("ready_in_mid_reset", 32'(req_ready_s[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("ready_after_mid_reset", 32'(req_ready_s[0]), 32'd1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid_s[0] === 1'b1) pulses++;
    end
    chk("no_resp_after_reset", 32'(pulses), 32'd0);
    issue(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b1, a);

    // Zero wait states: response in cycle 2, next accept in cycle 3.
    issue(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, a);
    issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, a1);
    issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, a2);
    chk("w0_accept_spacing", 32'(a2 - a1), 32'd3);
    wait_idle();

    // Randomised mix of loads, stores and faulting addresses.
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      addr = 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (r == 7) addr = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
      else if (r == 8) addr = 32'h400 + 32'(4 * $urandom_range(0, 1023));
      else             addr = 32'hFFFF_FFFC;
      issue(0, 1'($urandom), addr, $urandom, 4'($urandom), 1'b1, a);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
